// File: rtl/spram_access_ctrl.sv
// Valid/ready front end for a single-port RAM: clears the array after
// reset or clr, then serves one write per cycle or one read at a time.
module spram_access_ctrl #(
  parameter int              DW       = 4,
  parameter int              AW       = 4,
  parameter int              RD_LAT   = 1,
  parameter logic [DW-1:0]   INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy_init,
  output logic [DW-1:0] ram_data,
  output logic [AW-1:0] ram_add,
  output logic          ram_we,
  output logic          ram_rst,
  input  logic [DW-1:0] ram_out
);

  localparam int LW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_RD_WAIT,
    S_RSP
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_add_q, ram_add_d;
  logic [DW-1:0] ram_data_q, ram_data_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_d       = lat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    ram_we_d    = 1'b0;
    ram_add_d   = ram_add_q;
    ram_data_d  = ram_data_q;
    unique case (state_q)
      S_INIT: begin
        ram_we_d   = 1'b1;
        ram_add_d  = cnt_q;
        ram_data_d = INIT_VAL;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (clr) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end else if (req_valid) begin
          ram_add_d = req_addr;
          if (req_we) begin
            ram_we_d   = 1'b1;
            ram_data_d = req_wdata;
          end else begin
            lat_d   = '0;
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        // ram_add is held here; out is sampled RD_LAT+1 edges after accept
        if (lat_q == LW'(RD_LAT)) begin
          rsp_rdata_d = ram_out;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      lat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ram_we_q    <= 1'b0;
      ram_add_q   <= '0;
      ram_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      ram_we_q    <= ram_we_d;
      ram_add_q   <= ram_add_d;
      ram_data_q  <= ram_data_d;
    end
  end

  assign req_ready = (state_q == S_IDLE) && !clr && !rst;
  assign busy_init = (state_q == S_INIT);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_we    = ram_we_q;
  assign ram_add   = ram_add_q;
  assign ram_data  = ram_data_q;
  assign ram_rst   = rst;

endmodule
